// File: rtl/stack_bus_upstream_arb.sv
// stack_bus_upstream_arb: round-robin, packet-atomic arbiter from the PE array onto one registered upstream port.
// Optional parity output is enabled by defining STACK_BUS_UPSTREAM_PARITY_EN.
module stack_bus_upstream_arb #(
    parameter int NUM_PE        = 16,
    parameter int ID_W          = 4,
    parameter int DATA_W        = 64,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic [NUM_PE-1:0]        pe__stu__valid,
    input  logic [2*NUM_PE-1:0]      pe__stu__cntl,
    input  logic [DATA_W*NUM_PE-1:0] pe__stu__data,
    output logic [NUM_PE-1:0]        stu__pe__ready,
    output logic                     stu__sys__valid,
    output logic [1:0]               stu__sys__cntl,
    output logic [ID_W-1:0]          stu__sys__peId,
    output logic [DATA_W-1:0]        stu__sys__data,
    input  logic                     sys__stu__ready,
    output logic                     stu__sys__error
`ifdef STACK_BUS_UPSTREAM_PARITY_EN
    ,
    output logic                     stu__sys__parity
`endif
);
    localparam int CNT_W = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, PKT, GAP} state_t;

    state_t            state;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   search_idx;
    logic [ID_W-1:0]   cur_idx;
    logic [ID_W:0]     cand;
    logic [CNT_W-1:0]  beat_cnt;
    logic              found;
    logic              active;
    logic              load_ok;
    logic              sel_valid;
    logic              accept;
    logic              first_beat;
    logic              frame_err;
    logic              overlen;
    logic              release_pkt;
    logic [1:0]        sel_cntl;
    logic [1:0]        out_cntl;
    logic [DATA_W-1:0] sel_data;

    // Rotating priority search starting just after the last released PE.
    always_comb begin
        found      = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_PE; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_PE)) begin
                cand = cand - (ID_W+1)'(NUM_PE);
            end
            if (!found && pe__stu__valid[cand[ID_W-1:0]]) begin
                found      = 1'b1;
                search_idx = cand[ID_W-1:0];
            end
        end
    end

    assign load_ok     = !stu__sys__valid || sys__stu__ready;
    assign active      = (state == PKT) || ((state == IDLE) && found);
    assign cur_idx     = (state == IDLE) ? search_idx : gnt;
    assign sel_valid   = pe__stu__valid[cur_idx];
    assign sel_cntl    = pe__stu__cntl[2*cur_idx +: 2];
    assign sel_data    = pe__stu__data[DATA_W*cur_idx +: DATA_W];
    assign accept      = reset_poweron && active && load_ok && sel_valid;
    assign first_beat  = (beat_cnt == '0);
    assign frame_err   = first_beat ? !sel_cntl[0] : sel_cntl[0];
    assign overlen     = (beat_cnt == CNT_W'(MAX_PKT_BEATS-1)) && !sel_cntl[1];
    assign out_cntl    = overlen ? 2'b10 : sel_cntl;
    assign release_pkt = accept && (sel_cntl[1] || overlen);
    assign stu__sys__error = accept && (frame_err || overlen);

    // Only the granted PE sees ready; reset forces every ready low.
    always_comb begin
        stu__pe__ready = '0;
        if (reset_poweron && active) begin
            stu__pe__ready[cur_idx] = load_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state           <= IDLE;
            gnt             <= '0;
            rr_ptr          <= ID_W'(NUM_PE-1);
            beat_cnt        <= '0;
            stu__sys__valid <= 1'b0;
            stu__sys__cntl  <= '0;
            stu__sys__peId  <= '0;
            stu__sys__data  <= '0;
`ifdef STACK_BUS_UPSTREAM_PARITY_EN
            stu__sys__parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= search_idx;
                        state <= PKT;
                    end
                end
                PKT: begin
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A release (EOP or forced) overrides the IDLE->PKT move for single-beat packets.
            if (release_pkt) begin
                rr_ptr   <= cur_idx;
                beat_cnt <= '0;
                state    <= GAP;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (accept) begin
                stu__sys__valid <= 1'b1;
                stu__sys__cntl  <= out_cntl;
                stu__sys__peId  <= cur_idx;
                stu__sys__data  <= sel_data;
`ifdef STACK_BUS_UPSTREAM_PARITY_EN
                stu__sys__parity <= ^{out_cntl, cur_idx, sel_data};
`endif
            end else if (sys__stu__ready) begin
                stu__sys__valid <= 1'b0;
            end
        end
    end
endmodule
